// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage LEGv8 pipeline: load-use bubbles, taken-branch flushes, data-memory freeze.
// Latency: all controls are combinational from the current inputs/state; counters and mem_err update on the next edge.
// Backpressure: an outstanding data-memory access (memop without dmem_ready) freezes every pipeline register until ready or timeout.
//
// Ports:
//   clk, reset            - clock and asynchronous active-low reset
//   ID_EX_*/IF_ID_*       - load-use detection inputs (EX load destination vs ID sources)
//   EX_MEM_*              - MEM stage memory op / taken branch
//   dmem_ready/dmem_req   - data-memory handshake
//   *_write / *_flush     - pipeline register enables and control-field clears
//   mem_err               - sticky memory timeout flag
//   stall_cnt, flush_cnt  - saturating performance counters
module pipeline_hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ID_EX_memRead,
  input  logic [4:0]       ID_EX_rd,
  input  logic [4:0]       IF_ID_rn1,
  input  logic [4:0]       IF_ID_rm2,
  input  logic             IF_ID_usesRm2,
  input  logic             EX_MEM_memRead,
  input  logic             EX_MEM_memWrite,
  input  logic             EX_MEM_branchTaken,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             ID_EX_write,
  output logic             EX_MEM_write,
  output logic             MEM_WB_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             EX_MEM_flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  localparam logic [7:0] TIMEOUT_VAL = 8'(MEM_TIMEOUT);

  state_t     state, state_nxt;
  logic [7:0] wcnt, wcnt_nxt;
  logic       memop;
  logic       load_use;
  logic       set_err;
  logic       branch_evt;

  assign memop = EX_MEM_memRead | EX_MEM_memWrite;

  // XZR (register 31) always reads zero, so a load targeting it creates no dependency.
  assign load_use = ID_EX_memRead && (ID_EX_rd != 5'd31) &&
                    ((ID_EX_rd == IF_ID_rn1) || (IF_ID_usesRm2 && (ID_EX_rd == IF_ID_rm2)));

  always_comb begin
    state_nxt    = state;
    wcnt_nxt     = wcnt;
    set_err      = 1'b0;
    branch_evt   = 1'b0;
    dmem_req     = 1'b0;
    PC_write     = 1'b1;
    IF_ID_write  = 1'b1;
    ID_EX_write  = 1'b1;
    EX_MEM_write = 1'b1;
    MEM_WB_write = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_flush  = 1'b0;
    EX_MEM_flush = 1'b0;

    case (state)
      RUN: begin
        dmem_req = memop;
        if (memop && !dmem_ready) begin
          // Freeze beats branch and load-use: nothing may move while MEM is blocked.
          {PC_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write} = 5'b0;
          state_nxt = MEM_WAIT;
          wcnt_nxt  = 8'd1;
        end else if (EX_MEM_branchTaken) begin
          // The ID instruction is discarded, so any load-use on it is moot.
          IF_ID_flush  = 1'b1;
          ID_EX_flush  = 1'b1;
          EX_MEM_flush = 1'b1;
          branch_evt   = 1'b1;
        end else if (load_use) begin
          PC_write    = 1'b0;
          IF_ID_write = 1'b0;
          ID_EX_flush = 1'b1;
        end
      end
      MEM_WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ready) begin
          state_nxt = RUN;
          wcnt_nxt  = 8'd0;
        end else if (wcnt == TIMEOUT_VAL) begin
          // Abandon the access and let the pipeline advance this cycle.
          set_err   = 1'b1;
          state_nxt = RUN;
          wcnt_nxt  = 8'd0;
        end else begin
          {PC_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write} = 5'b0;
          wcnt_nxt = wcnt + 8'd1;
        end
      end
      default: begin
        state_nxt = RUN;
        wcnt_nxt  = 8'd0;
      end
    endcase

    // Reset must drop the request immediately, even mid-access.
    if (!reset) begin
      dmem_req     = 1'b0;
      PC_write     = 1'b1;
      IF_ID_write  = 1'b1;
      ID_EX_write  = 1'b1;
      EX_MEM_write = 1'b1;
      MEM_WB_write = 1'b1;
      IF_ID_flush  = 1'b0;
      ID_EX_flush  = 1'b0;
      EX_MEM_flush = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      wcnt      <= 8'd0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (set_err) mem_err <= 1'b1;
      if (!PC_write && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (branch_evt && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
